// File: rtl/coherence_pkg.sv
// Shared types and constants for the directory coherence controller.
package coherence_pkg;

  typedef enum logic [1:0] {
    DIR_I = 2'd0,
    DIR_S = 2'd1,
    DIR_M = 2'd2
  } dir_state_t;

  typedef enum logic [1:0] {
    OP_GETS = 2'd0,
    OP_GETM = 2'd1,
    OP_PUT  = 2'd2
  } req_op_t;

  localparam logic [2:0] SNP_INV       = 3'd1;
  localparam logic [2:0] SNP_DOWNGRADE = 3'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    SNOOP  = 2'd2,
    GRANT  = 2'd3
  } fsm_state_t;

  // The reserved encoding behaves as a Put.
  function automatic req_op_t decodeOp(logic [1:0] raw);
    case (raw)
      2'd0:    decodeOp = OP_GETS;
      2'd1:    decodeOp = OP_GETM;
      default: decodeOp = OP_PUT;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting at the pointer, pointer moves past the winner on accept.
module rr_arbiter #(
  parameter int NUM_CORES = 2,
  localparam int IDX_W = $clog2(NUM_CORES)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_CORES-1:0] reqVec,
  input  logic                 accept,
  output logic [NUM_CORES-1:0] grant,
  output logic [IDX_W-1:0]     grantIdx
);

  logic [IDX_W-1:0] ptr;

  always_comb begin
    logic        found;
    int unsigned idx;
    grant    = '0;
    grantIdx = '0;
    found    = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      idx = (int'(ptr) + i) % NUM_CORES;
      if (!found && reqVec[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        grantIdx    = IDX_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (accept && (|reqVec)) begin
      ptr <= (grantIdx == IDX_W'(NUM_CORES - 1)) ? '0 : grantIdx + 1'b1;
    end
  end

endmodule

// File: rtl/coherence_directory.sv
// Directory controller: serialises L1 coherence requests, snoops affected caches and grants MSI permissions.
//   state  | meaning
//   IDLE   | arbitrate and capture one request
//   LOOKUP | read entry, compute snoop targets
//   SNOOP  | wait for all pending snoop acks
//   GRANT  | pulse response, update entry
module coherence_directory
  import coherence_pkg::*;
#(
  parameter int NUM_CORES = 2,
  parameter int ADDR_W    = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CORES-1:0]        req_valid,
  output logic [NUM_CORES-1:0]        req_ready,
  input  logic [2*NUM_CORES-1:0]      req_op,
  input  logic [ADDR_W*NUM_CORES-1:0] req_addr,
  output logic [NUM_CORES-1:0]        snp_valid,
  output logic [2:0]                  snp_msg,
  output logic [ADDR_W-1:0]           snp_addr,
  input  logic [NUM_CORES-1:0]        snp_ack,
  output logic [NUM_CORES-1:0]        rsp_valid,
  output logic [1:0]                  rsp_state,
  output logic [ADDR_W-1:0]           rsp_addr
);

  localparam int IDX_W = $clog2(NUM_CORES);
  localparam int DEPTH = 2 ** ADDR_W;

  fsm_state_t state, stateNxt;

  logic [IDX_W-1:0]     reqCore;
  req_op_t              reqOp;
  logic [ADDR_W-1:0]    reqAddr;
  logic [NUM_CORES-1:0] pendMask;
  logic [2:0]           snpMsgQ;

  logic                 accept;
  logic [NUM_CORES-1:0] winGrant;
  logic [IDX_W-1:0]     winIdx;
  logic [1:0]           winOpRaw;
  logic [ADDR_W-1:0]    winAddr;

  dir_state_t           dirState   [DEPTH];
  logic [NUM_CORES-1:0] dirSharers [DEPTH];
  logic [IDX_W-1:0]     dirOwner   [DEPTH];

  dir_state_t           curState, updState, grantState;
  logic [NUM_CORES-1:0] curSharers, newSharers, reqBit, ownBit, snpTarget;
  logic [IDX_W-1:0]     curOwner, updOwner;
  logic                 isOwner;
  logic [2:0]           snpMsgD;

  rr_arbiter #(.NUM_CORES(NUM_CORES)) uArb (
    .clk      (clk),
    .rst_n    (rst_n),
    .reqVec   (req_valid),
    .accept   (accept),
    .grant    (winGrant),
    .grantIdx (winIdx)
  );

  assign winOpRaw = req_op[int'(winIdx)*2 +: 2];
  assign winAddr  = req_addr[int'(winIdx)*ADDR_W +: ADDR_W];

  assign curState   = dirState[reqAddr];
  assign curSharers = dirSharers[reqAddr];
  assign curOwner   = dirOwner[reqAddr];
  assign isOwner    = (curState == DIR_M) && (curOwner == reqCore);

  always_comb begin
    reqBit          = '0;
    reqBit[reqCore] = 1'b1;
    ownBit          = '0;
    ownBit[curOwner] = 1'b1;
  end

  always_comb begin
    snpTarget = '0;
    snpMsgD   = SNP_INV;
    case (reqOp)
      OP_GETS: begin
        if (curState == DIR_M && !isOwner) begin
          snpTarget = ownBit;
          snpMsgD   = SNP_DOWNGRADE;
        end
      end
      OP_GETM: begin
        if (curState == DIR_S) snpTarget = curSharers & ~reqBit;
        else if (curState == DIR_M && !isOwner) snpTarget = ownBit;
      end
      default: ;
    endcase
  end

  always_comb begin
    updState   = curState;
    newSharers = curSharers;
    updOwner   = curOwner;
    grantState = DIR_I;
    case (reqOp)
      OP_GETS: begin
        if (isOwner) begin
          grantState = DIR_M;
        end else begin
          // A downgraded owner keeps its sharer bit.
          updState   = DIR_S;
          newSharers = curSharers | reqBit;
          grantState = DIR_S;
        end
      end
      OP_GETM: begin
        updState   = DIR_M;
        newSharers = reqBit;
        updOwner   = reqCore;
        grantState = DIR_M;
      end
      default: begin
        newSharers = curSharers & ~reqBit;
        if (isOwner || newSharers == '0) updState = DIR_I;
      end
    endcase
  end

  always_comb begin
    stateNxt  = state;
    accept    = 1'b0;
    req_ready = '0;
    snp_valid = '0;
    rsp_valid = '0;
    rsp_state = DIR_I;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          accept    = 1'b1;
          req_ready = winGrant;
          stateNxt  = LOOKUP;
        end
      end
      LOOKUP: stateNxt = (snpTarget == '0) ? GRANT : SNOOP;
      SNOOP: begin
        snp_valid = pendMask;
        if ((pendMask & ~snp_ack) == '0) stateNxt = GRANT;
      end
      GRANT: begin
        rsp_valid = reqBit;
        rsp_state = grantState;
        stateNxt  = IDLE;
      end
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      reqCore  <= '0;
      reqOp    <= OP_GETS;
      reqAddr  <= '0;
      pendMask <= '0;
      snpMsgQ  <= '0;
    end else begin
      state <= stateNxt;
      if (accept) begin
        reqCore <= winIdx;
        reqOp   <= decodeOp(winOpRaw);
        reqAddr <= winAddr;
      end
      if (state == LOOKUP) begin
        pendMask <= snpTarget;
        snpMsgQ  <= snpMsgD;
      end else if (state == SNOOP) begin
        pendMask <= pendMask & ~snp_ack;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        dirState[i]   <= DIR_I;
        dirSharers[i] <= '0;
        dirOwner[i]   <= '0;
      end
    end else if (state == GRANT) begin
      dirState[reqAddr]   <= updState;
      dirSharers[reqAddr] <= newSharers;
      dirOwner[reqAddr]   <= updOwner;
    end
  end

  assign snp_msg  = snpMsgQ;
  assign snp_addr = reqAddr;
  assign rsp_addr = reqAddr;

endmodule

// File: tb/tb_coherence_directory.sv
// Directed bench for coherence_directory with a 2-core and a 4-core instance.
module tb_coherence_directory;

  localparam logic [1:0] ST_I = 2'd0, ST_S = 2'd1, ST_M = 2'd2;
  localparam logic [1:0] GETS = 2'd0, GETM = 2'd1, PUT = 2'd2, RSVD = 2'd3;
  localparam logic [2:0] INV = 3'd1, DNG = 3'd2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rv = '0, rr, sv, sa = '0, pv;
  logic [3:0]  rop = '0;
  logic [15:0] raddr = '0;
  logic [2:0]  smsg;
  logic [7:0]  saddr, paddr;
  logic [1:0]  pst;

  logic [3:0]  rv4 = '0, rr4, sv4, sa4 = '0, pv4;
  logic [7:0]  rop4 = '0;
  logic [31:0] raddr4 = '0;
  logic [2:0]  smsg4;
  logic [7:0]  saddr4, paddr4;
  logic [1:0]  pst4;

  int nVec = 0;
  int nMis = 0;

  coherence_directory #(.NUM_CORES(2), .ADDR_W(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv), .req_ready(rr), .req_op(rop), .req_addr(raddr),
    .snp_valid(sv), .snp_msg(smsg), .snp_addr(saddr), .snp_ack(sa),
    .rsp_valid(pv), .rsp_state(pst), .rsp_addr(paddr)
  );

  coherence_directory #(.NUM_CORES(4), .ADDR_W(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv4), .req_ready(rr4), .req_op(rop4), .req_addr(raddr4),
    .snp_valid(sv4), .snp_msg(smsg4), .snp_addr(saddr4), .snp_ack(sa4),
    .rsp_valid(pv4), .rsp_state(pst4), .rsp_addr(paddr4)
  );

  task automatic chkVec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVec++;
    if (got !== exp) begin
      nMis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic txn2(input int core, input logic [1:0] op, input logic [7:0] addr,
                      input logic [1:0] expSnp, input logic [2:0] expMsg, input logic [1:0] expSt);
    logic [1:0] oh;
    oh = '0;
    oh[core] = 1'b1;
    @(negedge clk);
    rv = oh;
    rop[core*2 +: 2] = op;
    raddr[core*8 +: 8] = addr;
    #1 chkVec("ready", rr, oh);
    @(posedge clk);
    #1 rv = '0;
    @(negedge clk);
    chkVec("lookupQuiet", {pv, sv, rr}, 0);
    @(negedge clk);
    if (expSnp != 2'b00) begin
      chkVec("snpValid", sv, expSnp);
      chkVec("snpMsg", smsg, expMsg);
      chkVec("snpAddr", saddr, addr);
      chkVec("noEarlyRsp", pv, 0);
      sa = expSnp;
      @(posedge clk);
      #1 sa = '0;
      @(negedge clk);
    end else begin
      chkVec("noSnoop", sv, 0);
    end
    chkVec("rspValid", pv, oh);
    chkVec("rspState", pst, expSt);
    chkVec("rspAddr", paddr, addr);
  endtask

  task automatic race2(input logic [1:0] op0, input logic [1:0] op1, input logic [7:0] addr,
                       input logic [1:0] expSt0, input logic [1:0] expSt1);
    @(negedge clk);
    rv = 2'b11;
    rop = {op1, op0};
    raddr = {addr, addr};
    #1 chkVec("raceReady0", rr, 2'b01);
    @(posedge clk);
    #1 rv = 2'b10;
    @(negedge clk);
    chkVec("busyReady", rr, 0);
    @(negedge clk);
    chkVec("raceRsp0", pv, 2'b01);
    chkVec("raceSt0", pst, expSt0);
    chkVec("raceNoSnp0", sv, 0);
    @(negedge clk);
    chkVec("raceReady1", rr, 2'b10);
    @(posedge clk);
    #1 rv = '0;
    @(negedge clk);
    @(negedge clk);
    chkVec("raceRsp1", pv, 2'b10);
    chkVec("raceSt1", pst, expSt1);
    chkVec("raceNoSnp1", sv, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] oh4;
    repeat (3) @(negedge clk);
    chkVec("rst2", {rr, sv, pv, pst, smsg, saddr, paddr}, 0);
    chkVec("rst4", {rr4, sv4, pv4, pst4, smsg4, saddr4, paddr4}, 0);
    rst_n = 1'b1;

    // Basic GetS: grant at cycle 2, no snoop.
    txn2(0, GETS, 8'h10, 2'b00, INV, ST_S);

    // Shared line upgraded by core 1: only core 0 invalidated.
    txn2(0, GETS, 8'h20, 2'b00, INV, ST_S);
    txn2(1, GETS, 8'h20, 2'b00, INV, ST_S);
    txn2(1, GETM, 8'h20, 2'b01, INV, ST_M);
    txn2(0, GETS, 8'h20, 2'b10, DNG, ST_S);

    // M owner downgraded; both remain sharers.
    txn2(0, GETM, 8'h30, 2'b00, INV, ST_M);
    txn2(1, GETS, 8'h30, 2'b01, DNG, ST_S);
    txn2(1, GETM, 8'h30, 2'b01, INV, ST_M);
    txn2(1, GETS, 8'h30, 2'b00, INV, ST_M);
    txn2(1, GETM, 8'h30, 2'b00, INV, ST_M);

    // Simultaneous requests alternate; non-sharer Put then owner Put (reserved op).
    race2(PUT, RSVD, 8'h30, ST_I, ST_I);
    race2(GETS, GETS, 8'h30, ST_S, ST_S);

    // Four-core invalidate fan-out with split acks and a stray ack from core 3.
    for (int c = 0; c < 3; c++) begin
      oh4 = '0;
      oh4[c] = 1'b1;
      @(negedge clk);
      rv4 = oh4;
      rop4[c*2 +: 2] = GETS;
      raddr4[c*8 +: 8] = 8'h60;
      #1 chkVec("ready4", rr4, oh4);
      @(posedge clk);
      #1 rv4 = '0;
      @(negedge clk);
      @(negedge clk);
      chkVec("rsp4", pv4, oh4);
      chkVec("st4", pst4, ST_S);
      chkVec("noSnp4", sv4, 0);
    end
    @(negedge clk);
    rv4 = 4'b1000;
    rop4[7:6] = GETM;
    raddr4[31:24] = 8'h60;
    #1 chkVec("ready4m", rr4, 4'b1000);
    @(posedge clk);
    #1 rv4 = '0;
    @(negedge clk);
    @(negedge clk);
    chkVec("snp4All", sv4, 4'b0111);
    chkVec("snp4Msg", smsg4, INV);
    chkVec("snp4Addr", saddr4, 8'h60);
    sa4 = 4'b1011;
    @(posedge clk);
    #1 sa4 = '0;
    @(negedge clk);
    chkVec("snp4Left", sv4, 4'b0100);
    chkVec("noRsp4", pv4, 0);
    sa4 = 4'b0100;
    @(posedge clk);
    #1 sa4 = '0;
    @(negedge clk);
    chkVec("rsp4m", pv4, 4'b1000);
    chkVec("st4m", pst4, ST_M);
    chkVec("snp4Done", sv4, 0);

    // Reset mid-snoop aborts; the line comes back as I.
    txn2(0, GETM, 8'h50, 2'b00, INV, ST_M);
    @(negedge clk);
    rv = 2'b10;
    rop[3:2] = GETS;
    raddr[15:8] = 8'h50;
    @(posedge clk);
    #1 rv = '0;
    @(negedge clk);
    @(negedge clk);
    chkVec("preRstSnp", sv, 2'b01);
    chkVec("preRstMsg", smsg, DNG);
    #2 rst_n = 1'b0;
    #1 chkVec("rstSnpDrop", sv, 0);
    chkVec("rstNoRsp", pv, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    txn2(1, GETS, 8'h50, 2'b00, INV, ST_S);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
